// File: rtl/clock_bcd_scanner_pkg.sv
// Shared definitions for the desk-clock display scanner: field indices, converter
// timing and the small helpers used for 12 h mapping and double-dabble adjustment.
package clock_pkg;

    typedef enum logic [1:0] {
        FIELD_HOURS = 2'd0,
        FIELD_MIN   = 2'd1,
        FIELD_SEC   = 2'd2
    } field_e;

    localparam int CONV_CYCLES = 7;
    localparam int BIN_W       = 7;

    typedef logic [3:0] bcd_t;

    function automatic logic [BIN_W-1:0] map_hours(input logic [4:0] hours, input logic mode_12h);
        logic [4:0] h;
        h = hours;
        if (mode_12h) begin
            if (hours == 5'd0) begin
                h = 5'd12;
            end else if (hours > 5'd12) begin
                h = hours - 5'd12;
            end
        end
        return {2'b00, h};
    endfunction

    function automatic bcd_t bcd_adj(input bcd_t n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

endpackage

// File: rtl/clock_bcd_scanner_if.sv
// Display-scanner bus: time/enable inputs from the clock counters, digit outputs
// towards the 7-segment encoder.
interface clock_bcd_scanner_if
    import clock_pkg::*;
#(
    parameter int NUM_DIGITS = 6
) ();

    logic                  i_ena;
    logic                  i_mode_12h;
    logic [4:0]            i_hours;
    logic [5:0]            i_minutes;
    logic [5:0]            i_seconds;
    logic [NUM_DIGITS-1:0] i_dp;
    logic [NUM_DIGITS-1:0] o_digit_sel;
    bcd_t                  o_bcd;
    logic                  o_dp;
    logic                  o_blank;
    logic                  o_pm;
    logic                  o_frame_start;

    modport master (
        output i_ena, i_mode_12h, i_hours, i_minutes, i_seconds, i_dp,
        input  o_digit_sel, o_bcd, o_dp, o_blank, o_pm, o_frame_start
    );

    modport slave (
        input  i_ena, i_mode_12h, i_hours, i_minutes, i_seconds, i_dp,
        output o_digit_sel, o_bcd, o_dp, o_blank, o_pm, o_frame_start
    );

endinterface

// File: rtl/clock_bcd_scanner_bin_to_bcd.sv
// Serial double-dabble: 7-bit binary to two BCD nibbles. The MSB is shifted in at
// load (it can never need an add-3), leaving six adjust/shift iterations.
module bin_to_bcd_serial
    import clock_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_en,
    input  logic             i_start,
    input  logic [BIN_W-1:0] i_bin,
    output bcd_t             o_tens,
    output bcd_t             o_ones,
    output logic             o_done
);

    localparam logic [2:0] ITERS = 3'(CONV_CYCLES - 1);

    bcd_t       tens_q, tens_d;
    bcd_t       ones_q, ones_d;
    logic [5:0] sr_q, sr_d;
    logic [2:0] iter_q, iter_d;
    logic       loaded_q, loaded_d;

    always_comb begin
        tens_d   = tens_q;
        ones_d   = ones_q;
        sr_d     = sr_q;
        iter_d   = iter_q;
        loaded_d = loaded_q;
        if (i_en) begin
            if (i_start) begin
                tens_d   = 4'd0;
                ones_d   = {3'b000, i_bin[6]};
                sr_d     = i_bin[5:0];
                iter_d   = ITERS;
                loaded_d = 1'b1;
            end else if (iter_q != 3'd0) begin
                {tens_d, ones_d, sr_d} = {bcd_adj(tens_q), bcd_adj(ones_q), sr_q} << 1;
                iter_d = iter_q - 3'd1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            tens_q   <= 4'd0;
            ones_q   <= 4'd0;
            sr_q     <= 6'd0;
            iter_q   <= 3'd0;
            loaded_q <= 1'b0;
        end else begin
            tens_q   <= tens_d;
            ones_q   <= ones_d;
            sr_q     <= sr_d;
            iter_q   <= iter_d;
            loaded_q <= loaded_d;
        end
    end

    assign o_tens = tens_q;
    assign o_ones = ones_q;
    assign o_done = loaded_q && (iter_q == 3'd0);

endmodule

// File: rtl/clock_bcd_scanner.sv
// Time-multiplexed BCD digit scanner: per-frame snapshot, per-slot reconversion,
// dead time at slot entry. Every output is a register reflecting the last clock edge.
module clock_bcd_scanner
    import clock_pkg::*;
#(
    parameter int NUM_DIGITS    = 6,
    parameter int SCAN_CYCLES   = 1000,
    parameter int BLANK_LEADING = 1
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    clock_bcd_scanner_if.slave bus
);

    localparam logic [15:0] P_LAST = 16'(SCAN_CYCLES - 1);
    localparam logic [15:0] P_SHOW = 16'(CONV_CYCLES);
    localparam logic [2:0]  K_LAST = 3'(NUM_DIGITS - 1);

    logic [15:0]           p_q, p_d;
    logic [2:0]            k_q, k_d;
    logic [4:0]            hours_q;
    logic [5:0]            minutes_q, seconds_q;
    logic                  mode_q;
    logic                  pm_q, frame_q, dp_slot_q, dp_q, blank_q;
    logic [NUM_DIGITS-1:0] sel_q, sel_d;
    bcd_t                  bcd_q;

    logic                  load, snap, show, dp_pick;
    logic [4:0]            hours_src;
    logic                  mode_src;
    logic [BIN_W-1:0]      conv_bin;
    bcd_t                  conv_tens, conv_ones;
    logic                  conv_done;

    always_comb begin
        p_d = p_q;
        k_d = k_q;
        if (bus.i_ena) begin
            if (p_q == P_LAST) begin
                p_d = 16'd0;
                k_d = (k_q == K_LAST) ? 3'd0 : k_q + 3'd1;
            end else begin
                p_d = p_q + 16'd1;
            end
        end
    end

    assign load = bus.i_ena && (p_q == 16'd0);
    assign snap = load && (k_q == 3'd0);
    assign show = bus.i_ena && (p_q == P_SHOW) && conv_done;

    // Slot 0 converts the inputs being snapshotted on this very edge.
    assign hours_src = snap ? bus.i_hours    : hours_q;
    assign mode_src  = snap ? bus.i_mode_12h : mode_q;

    always_comb begin
        conv_bin = {1'b0, seconds_q};
        if (k_q[2:1] == 2'(FIELD_HOURS)) begin
            conv_bin = map_hours(hours_src, mode_src);
        end else if (k_q[2:1] == 2'(FIELD_MIN)) begin
            conv_bin = {1'b0, minutes_q};
        end
    end

    always_comb begin
        sel_d   = '0;
        dp_pick = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (k_q == 3'(i)) begin
                sel_d[i] = bus.i_ena && (p_q >= P_SHOW);
                dp_pick  = bus.i_dp[i];
            end
        end
    end

    bin_to_bcd_serial u_conv (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_en      (bus.i_ena),
        .i_start   (load),
        .i_bin     (conv_bin),
        .o_tens    (conv_tens),
        .o_ones    (conv_ones),
        .o_done    (conv_done)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            p_q       <= 16'd0;
            k_q       <= 3'd0;
            hours_q   <= 5'd0;
            minutes_q <= 6'd0;
            seconds_q <= 6'd0;
            mode_q    <= 1'b0;
            pm_q      <= 1'b0;
            frame_q   <= 1'b0;
            dp_slot_q <= 1'b0;
            sel_q     <= '0;
            bcd_q     <= 4'd0;
            dp_q      <= 1'b0;
            blank_q   <= 1'b0;
        end else begin
            p_q     <= p_d;
            k_q     <= k_d;
            frame_q <= snap;
            sel_q   <= sel_d;
            if (snap) begin
                hours_q   <= bus.i_hours;
                minutes_q <= bus.i_minutes;
                seconds_q <= bus.i_seconds;
                mode_q    <= bus.i_mode_12h;
                pm_q      <= (bus.i_hours >= 5'd12);
            end
            if (load) begin
                dp_slot_q <= dp_pick;
            end
            if (show) begin
                bcd_q   <= k_q[0] ? conv_ones : conv_tens;
                dp_q    <= dp_slot_q;
                blank_q <= (BLANK_LEADING != 0) && (k_q == 3'd0) && (conv_tens == 4'd0);
            end
        end
    end

    assign bus.o_digit_sel   = sel_q;
    assign bus.o_bcd         = bcd_q;
    assign bus.o_dp          = dp_q;
    assign bus.o_blank       = blank_q;
    assign bus.o_pm          = pm_q;
    assign bus.o_frame_start = frame_q;

endmodule

// File: tb/tb_clock_bcd_scanner.sv
// Scoreboard bench for clock_bcd_scanner: a 6-digit and a 4-digit scanner share the
// same time inputs; a slot/frame model fills expectation queues, monitors drain them.
module tb_clock_bcd_scanner;

    localparam int SC = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       mode;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic [5:0] dp6;
    logic [3:0] dp4;

    always #5 clk = ~clk;

    clock_bcd_scanner_if #(.NUM_DIGITS(6)) bus6 ();
    clock_bcd_scanner_if #(.NUM_DIGITS(4)) bus4 ();

    assign bus6.i_ena      = ena;
    assign bus6.i_mode_12h = mode;
    assign bus6.i_hours    = hours;
    assign bus6.i_minutes  = minutes;
    assign bus6.i_seconds  = seconds;
    assign bus6.i_dp       = dp6;
    assign bus4.i_ena      = ena;
    assign bus4.i_mode_12h = mode;
    assign bus4.i_hours    = hours;
    assign bus4.i_minutes  = minutes;
    assign bus4.i_seconds  = seconds;
    assign bus4.i_dp       = dp4;

    clock_bcd_scanner #(.NUM_DIGITS(6), .SCAN_CYCLES(SC)) u_dut6 (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus6.slave)
    );

    clock_bcd_scanner #(.NUM_DIGITS(4), .SCAN_CYCLES(SC)) u_dut4 (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus4.slave)
    );

    typedef struct { int idx; int bcd; int dp; int blank; } slot_t;
    typedef struct { int sel; int fs; int pm; } cyc_t;

    slot_t slot_q0[$];
    slot_t slot_q1[$];
    cyc_t  cyc_q0[$];
    cyc_t  cyc_q1[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int u, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d got %0d expected %0d at %0t", name, (u == 0) ? 6 : 4, act, exp, $time);
        end
    endtask

    function automatic int field_val(input int k, input int h, input int m, input int s, input int md);
        int hv;
        hv = h;
        if (md != 0) begin
            if (h == 0) hv = 12;
            else if (h > 12) hv = h - 12;
        end
        case (k / 2)
            0:       return hv;
            1:       return m;
            default: return s;
        endcase
    endfunction

    // Reference model: slot k and phase p follow from the count of enabled edges.
    int    n_en[2];
    int    sh[2], sm[2], ss[2], smode[2], spm[2];
    int    md_nd, md_p, md_k, md_v, md_tens, md_ones, md_dpv;
    slot_t md_r;
    cyc_t  md_c;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int u = 0; u < 2; u++) begin
                n_en[u] = 0; sh[u] = 0; sm[u] = 0; ss[u] = 0; smode[u] = 0; spm[u] = 0;
            end
            slot_q0.delete(); slot_q1.delete();
            cyc_q0.delete();  cyc_q1.delete();
        end else begin
            for (int u = 0; u < 2; u++) begin
                md_nd  = (u == 0) ? 6 : 4;
                md_c.sel = 0;
                md_c.fs  = 0;
                if (ena) begin
                    md_p = n_en[u] % SC;
                    md_k = (n_en[u] / SC) % md_nd;
                    if (md_p == 0) begin
                        if (md_k == 0) begin
                            sh[u] = int'(hours); sm[u] = int'(minutes); ss[u] = int'(seconds);
                            smode[u] = int'(mode); spm[u] = (int'(hours) >= 12) ? 1 : 0;
                        end
                        md_v    = field_val(md_k, sh[u], sm[u], ss[u], smode[u]);
                        md_tens = md_v / 10;
                        md_ones = md_v % 10;
                        md_dpv  = (u == 0) ? int'(dp6) : int'(dp4);
                        md_r.idx   = md_k;
                        md_r.bcd   = (md_k % 2 == 0) ? md_tens : md_ones;
                        md_r.blank = (md_k == 0 && md_tens == 0) ? 1 : 0;
                        md_r.dp    = (md_dpv >> md_k) & 1;
                        if (u == 0) slot_q0.push_back(md_r);
                        else        slot_q1.push_back(md_r);
                    end
                    md_c.sel = (md_p >= 7) ? (1 << md_k) : 0;
                    md_c.fs  = (md_p == 0 && md_k == 0) ? 1 : 0;
                    n_en[u]++;
                end
                md_c.pm = spm[u];
                if (u == 0) cyc_q0.push_back(md_c);
                else        cyc_q1.push_back(md_c);
            end
        end
    end

    // Monitor: per-cycle select/frame/pm, per-slot digit contents when a new digit lights.
    int    last_idx[2];
    slot_t cur[2];
    int    m_sel, m_fs, m_pm, m_bcd, m_dp, m_bl, m_idx, m_sz;
    cyc_t  m_c;

    initial begin
        last_idx[0] = -1;
        last_idx[1] = -1;
    end

    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (u == 0) begin
                m_sel = int'(bus6.o_digit_sel); m_fs = int'(bus6.o_frame_start); m_pm = int'(bus6.o_pm);
                m_bcd = int'(bus6.o_bcd);       m_dp = int'(bus6.o_dp);          m_bl = int'(bus6.o_blank);
            end else begin
                m_sel = int'(bus4.o_digit_sel); m_fs = int'(bus4.o_frame_start); m_pm = int'(bus4.o_pm);
                m_bcd = int'(bus4.o_bcd);       m_dp = int'(bus4.o_dp);          m_bl = int'(bus4.o_blank);
            end
            if (!rst_n) begin
                last_idx[u] = -1;
                check("reset_zero", u, m_sel | m_fs | m_pm | m_bcd | m_dp | m_bl, 0);
            end else begin
                m_c.sel = 0; m_c.fs = 0; m_c.pm = 0;
                if (u == 0 && cyc_q0.size() > 0) m_c = cyc_q0.pop_front();
                if (u == 1 && cyc_q1.size() > 0) m_c = cyc_q1.pop_front();
                check("digit_sel", u, m_sel, m_c.sel);
                check("frame_start", u, m_fs, m_c.fs);
                check("pm", u, m_pm, m_c.pm);
                if (m_sel != 0) begin
                    m_idx = -2;
                    for (int j = 0; j < 6; j++) if (m_sel == (1 << j)) m_idx = j;
                    if (m_idx != last_idx[u]) begin
                        m_sz = (u == 0) ? slot_q0.size() : slot_q1.size();
                        check("slot_queue_nonempty", u, (m_sz > 0) ? 1 : 0, 1);
                        if (m_sz > 0) begin
                            cur[u] = (u == 0) ? slot_q0.pop_front() : slot_q1.pop_front();
                            check("slot_index", u, m_idx, cur[u].idx);
                        end
                        last_idx[u] = m_idx;
                    end
                end
                if (last_idx[u] >= 0) begin
                    check("bcd", u, m_bcd, cur[u].bcd);
                    check("dp", u, m_dp, cur[u].dp);
                    check("blank", u, m_bl, cur[u].blank);
                end
            end
        end
    end

    task automatic tick(input int nc);
        repeat (nc) @(posedge clk);
        #1;
    endtask

    task automatic set_time(input int h, input int m, input int s);
        hours   = 5'(h);
        minutes = 6'(m);
        seconds = 6'(s);
    endtask

    // Bounded wait until the next edge of the 6-digit scanner lands on a given frame position.
    task automatic wait_pos(input int target);
        int guard;
        guard = 0;
        while ((n_en[0] % (6 * SC)) != target && guard < 400) begin
            tick(1);
            guard++;
        end
        check("wait_pos_reached", 0, n_en[0] % (6 * SC), target);
    endtask

    initial begin
        rst_n = 1'b0;
        ena   = 1'b0;
        mode  = 1'b0;
        dp6   = 6'd0;
        dp4   = 4'd0;
        set_time(12, 30, 59);
        tick(3);
        rst_n = 1'b1;
        ena   = 1'b1;
        tick(200);

        mode = 1'b1;
        set_time(0, 7, 8);
        tick(200);
        hours = 5'd13;
        tick(200);
        hours = 5'd12;
        tick(200);
        hours = 5'd5;
        tick(200);

        mode = 1'b0;
        set_time(23, 15, 30);
        tick(100);
        wait_pos(3 * SC + 5);
        set_time(0, 0, 0);
        tick(200);

        set_time(23, 15, 30);
        tick(100);
        wait_pos(2 * SC + 3);
        ena = 1'b0;
        tick(50);
        ena = 1'b1;
        tick(150);

        wait_pos(4 * SC + 2);
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(150);

        dp4 = 4'b1000;
        dp6 = 6'b001000;
        set_time(9, 45, 17);
        tick(200);

        for (int i = 0; i < 25; i++) begin
            set_time(int'($urandom_range(0, 31)), int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
            mode = 1'($urandom_range(0, 1));
            dp6  = 6'($urandom_range(0, 63));
            dp4  = 4'($urandom_range(0, 15));
            ena  = ($urandom_range(0, 3) != 0);
            tick(int'($urandom_range(5, 120)));
        end
        ena = 1'b1;
        tick(200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
